seq_umul: RTL
=============

SEQ_UMUL -- requirements
Module: seq_umul

Interface
REQ-001 The module SHALL have parameter N_BIT, default 24, meaning the operand width (mantissa plus hidden bit).
REQ-002 The module SHALL have parameter RES_BIT, default 2*N_BIT, meaning the product width presented on out.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-005 The module SHALL have port start, input, 1 bit, a one-cycle request to begin a multiply.
REQ-006 The module SHALL have port a, input, N_BIT bits, the unsigned multiplicand, sampled only when start is accepted.
REQ-007 The module SHALL have port b, input, N_BIT bits, the unsigned multiplier, sampled only when start is accepted.
REQ-008 The module SHALL have port out, output, RES_BIT bits, the unsigned product a*b.
REQ-009 The module SHALL have port ready, output, 1 bit, high when out holds a complete product and a new start is accepted.

Function
REQ-010 The module SHALL have FSM states IDLE, RUN and DONE.
REQ-011 The FSM SHALL transition IDLE->RUN and DONE->RUN on a clock edge with start=1.
REQ-012 The FSM SHALL transition RUN->DONE on the edge that completes iteration N_BIT.
REQ-013 The FSM SHALL hold all other states when start=0.
REQ-014 On accepting start, the module SHALL latch a and b, clear the 2*N_BIT accumulator and load the iteration counter with 0.
REQ-015 In each RUN cycle, the module SHALL add the shifted multiplicand to the accumulator when the current multiplier LSB is 1, shift the multiplier right by 1, shift the multiplicand left by 1, and increment the counter.
REQ-016 The counter SHALL be $clog2(N_BIT+1) bits wide and SHALL never wrap during an operation.
REQ-017 Latency: with start sampled at edge E, ready SHALL be 0 from E through E+N_BIT-1 and 1 from edge E+N_BIT onward.
REQ-018 Latency SHALL be fixed and independent of operand values, with no early termination.
REQ-019 ready SHALL be high in IDLE and DONE and low in RUN.
REQ-020 out SHALL be the low RES_BIT bits of the exact 2*N_BIT product, zero-extended if RES_BIT > 2*N_BIT.
REQ-021 out SHALL update only on the RUN->DONE edge and SHALL be held stable in IDLE, DONE and throughout RUN.
REQ-022 A start asserted during RUN SHALL be ignored: operands are not resampled and the operation completes unchanged.
REQ-023 A start at the DONE edge SHALL be accepted back-to-back; out keeps the previous product until the new operation completes.
REQ-024 Changes on a or b after acceptance SHALL have no effect on the current operation.
REQ-025 The accumulator SHALL be 2*N_BIT bits wide so that no intermediate overflow is possible.

Reset
REQ-026 While rst=1, the module SHALL force state to IDLE, ready to 1, out to 0, and the counter, accumulator and operand registers to 0, asynchronously.
REQ-027 If rst asserts mid-operation, the operation SHALL be abandoned and no partial product SHALL ever appear on out.
REQ-028 Start SHALL be accepted on the first clock edge after rst deasserts.

Structure
REQ-029 The FSM state enum SHALL be defined in the shared arith_pkg package.
REQ-030 N_BIT and RES_BIT SHALL remain module parameters so that fpmul instantiates the block with N_BIT=MAN_BIT+1 and RES_BIT=2*MAN_BIT+2.
REQ-031 The block SHALL be implemented as a single module with no sub-module; the datapath is one adder plus shift registers.

Verification
REQ-032 After reset, the bench SHALL check ready=1 and out=0; with a=0xFFFFFF, b=0xFFFFFF and start, it SHALL check out=0xFFFFFE000001 with ready rising exactly 24 edges after the start edge.
REQ-033 With a=0x800000 and b=0x800000, the bench SHALL check out=0x400000000000; with a=0x000000 and b=0xABCDEF, it SHALL check out=0 after the same fixed 24-cycle latency.
REQ-034 The bench SHALL start a=3, b=5, pulse start again at cycle 5 with a=7, b=7, and check out=15 with no restart and the same latency.
REQ-035 The bench SHALL run back-to-back operations 3*4 then 6*7, with start at the DONE edge, and check out=12 held during the second run and then out=42.
REQ-036 The bench SHALL start 0x123456*0x654321, assert rst at cycle 10, and check ready=1 and out=0 immediately; after release, 2*2 SHALL give out=4.
REQ-037 The bench SHALL check 1000 random operand pairs against a reference model, including all-ones and single-bit operands.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: FSM state encoding for the
// sequential unsigned multiplier.
package arith_pkg;

  // IDLE: no product yet (or just reset); RUN: shift-add iterations;
  // DONE: out holds a finished product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } umul_state_e;

  // Width for a counter that must reach n without wrapping.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_umul.sv
// Sequential unsigned shift-add multiplier. One partial product per clock,
// fixed N_BIT-cycle latency. out changes only when a run finishes, so a
// partial product is never visible.
module seq_umul
  import arith_pkg::*;
#(
  parameter int N_BIT   = 24,
  parameter int RES_BIT = 2 * N_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_BIT-1:0]   a,
  input  logic [N_BIT-1:0]   b,
  output logic [RES_BIT-1:0] out,
  output logic               ready
);

  localparam int ACC_W = 2 * N_BIT;
  localparam int CNT_W = cnt_width(N_BIT);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(N_BIT - 1);

  umul_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic [ACC_W-1:0]   mcand_q,  mcand_d;
  logic [N_BIT-1:0]   mplier_q, mplier_d;
  logic [RES_BIT-1:0] out_q,    out_d;

  logic [ACC_W-1:0]   sum;
  logic [RES_BIT-1:0] sum_fit;

  // Single adder: accumulator plus the shifted multiplicand when the
  // current multiplier bit is set.
  assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Fit the full product onto the output width (truncate or zero-extend).
  if (RES_BIT > ACC_W) begin : g_ext
    assign sum_fit = {{(RES_BIT - ACC_W){1'b0}}, sum};
  end else if (RES_BIT == ACC_W) begin : g_eq
    assign sum_fit = sum;
  end else begin : g_trunc
    assign sum_fit = sum[RES_BIT-1:0];
  end

  // Next-state and datapath control; start is only honoured outside RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    out_d    = out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = {{N_BIT{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) begin
          state_d = DONE;
          out_d   = sum_fit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      out_q    <= out_d;
    end
  end

  assign out   = out_q;
  assign ready = (state_q != RUN);

endmodule
